// File: rtl/led_drv_pkg.sv
// Shared defaults and types for the LED PWM fade driver.
// Every file in this driver imports this package.
package led_drv_pkg;

    localparam int PWM_BITS_DEF = 8;
    localparam int NUM_LEDS_DEF = 10;

    // Full-scale level. A level at this value drives the LED constantly on.
    localparam int LED_LEVEL_MAX = (1 << PWM_BITS_DEF) - 1;

    typedef logic [PWM_BITS_DEF-1:0] level_t;

    // Subtracts step from level and clamps at zero, so a fading LED never wraps back to bright.
    function automatic level_t sat_decay(input level_t level, input int step);
        level_t result;
        result = '0;
        if (int'(level) > step) begin
            result = level - level_t'(step);
        end
        return result;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: a brightness level register updated only at PWM period starts,
// and a registered PWM compare driving the pin.
module led_fade_channel
    import led_drv_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int DECAY_STEP = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                period_start,
    input  logic                fade_step,
    input  logic                led_req,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                fade_en,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
    localparam logic [PWM_BITS-1:0] DECAY_W = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic                led_out_q, led_out_d;

    // A lit request beats a coincident fade step, so re-lighting mid-fade jumps straight to brightness.
    always_comb begin
        level_d   = level_q;
        led_out_d = 1'b0;
        if (enable) begin
            if (period_start) begin
                if (led_req) begin
                    level_d = brightness;
                end else if (!fade_en) begin
                    level_d = '0;
                end else if (fade_step) begin
                    level_d = (int'(level_q) > DECAY_STEP) ? (level_q - DECAY_W) : '0;
                end
            end
            led_out_d = (level_q == LVL_MAX) ? 1'b1 : (pwm_cnt < level_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q   <= '0;
            led_out_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            led_out_q <= led_out_d;
        end
    end

    assign led_out = led_out_q;

endmodule

// File: rtl/led_pwm_fade_driver.sv
// PWM brightness and afterglow driver for the PIO LEDs. It holds the shared timebase:
// a prescaler, a PWM counter, a fade divider and the period strobe.
module led_pwm_fade_driver
    import led_drv_pkg::*;
#(
    parameter int NUM_LEDS   = NUM_LEDS_DEF,
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int PRESCALE   = 49,
    parameter int FADE_DIV   = 4,
    parameter int DECAY_STEP = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                fade_en,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                period_strobe
);

    localparam int PRE_W  = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(PRESCALE);
    localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
    localparam logic [FADE_W-1:0]   FADE_MAX = FADE_W'(FADE_DIV - 1);
    localparam logic [FADE_W-1:0]   FADE_ONE = FADE_W'(1);
    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

    logic [PRE_W-1:0]    prescale_q, prescale_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FADE_W-1:0]   fade_cnt_q, fade_cnt_d;
    logic                period_strobe_q, period_strobe_d;
    logic [NUM_LEDS-1:0] led_in_q, led_in_d;

    logic pwm_tick;
    logic period_start;
    logic fade_step;

    // With enable low, every counter simply holds, so counting resumes exactly where it stopped.
    always_comb begin
        pwm_tick     = enable && (prescale_q == PRE_MAX);
        period_start = pwm_tick && (pwm_cnt_q == CNT_MAX);
        fade_step    = period_start && (fade_cnt_q == FADE_MAX);

        prescale_d = prescale_q;
        if (enable) begin
            prescale_d = (prescale_q == PRE_MAX) ? '0 : (prescale_q + PRE_ONE);
        end

        pwm_cnt_d = pwm_tick ? (pwm_cnt_q + CNT_ONE) : pwm_cnt_q;

        fade_cnt_d = fade_cnt_q;
        if (period_start) begin
            fade_cnt_d = (fade_cnt_q == FADE_MAX) ? '0 : (fade_cnt_q + FADE_ONE);
        end

        period_strobe_d = period_start;
        led_in_d        = led_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q      <= '0;
            pwm_cnt_q       <= '0;
            fade_cnt_q      <= '0;
            period_strobe_q <= 1'b0;
            led_in_q        <= '0;
        end else begin
            prescale_q      <= prescale_d;
            pwm_cnt_q       <= pwm_cnt_d;
            fade_cnt_q      <= fade_cnt_d;
            period_strobe_q <= period_strobe_d;
            led_in_q        <= led_in_d;
        end
    end

    assign period_strobe = period_strobe_q;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        led_fade_channel #(
            .PWM_BITS   (PWM_BITS),
            .DECAY_STEP (DECAY_STEP)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .enable       (enable),
            .period_start (period_start),
            .fade_step    (fade_step),
            .led_req      (led_in_q[i]),
            .brightness   (brightness),
            .fade_en      (fade_en),
            .pwm_cnt      (pwm_cnt_q),
            .led_out      (led_out[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_fade_driver.sv
// Self-checking bench for led_pwm_fade_driver: directed steps followed by a random phase,
// all compared against a per-period behavioural model.
module tb_led_pwm_fade_driver;

    localparam int NUM_LEDS   = 10;
    localparam int PWM_BITS   = 8;
    localparam int PRESCALE   = 0;
    localparam int FADE_DIV   = 1;
    localparam int DECAY_STEP = 50;
    localparam int PERIOD     = 1 << PWM_BITS;
    localparam int WAIT_LIMIT = 600;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [NUM_LEDS-1:0] led_in;
    logic [PWM_BITS-1:0] brightness;
    logic                fade_en;
    logic [NUM_LEDS-1:0] led_out;
    logic                period_strobe;

    int errors = 0;
    int checks = 0;

    // Reference model: total enabled clocks gives the PWM phase; levels change once per period.
    int                  m_ticks;
    int                  m_periods;
    int                  m_level [NUM_LEDS];
    logic [NUM_LEDS-1:0] m_led_in;
    logic [NUM_LEDS-1:0] m_out;
    logic                m_strobe;

    always #5 clk = ~clk;

    led_pwm_fade_driver #(
        .NUM_LEDS   (NUM_LEDS),
        .PWM_BITS   (PWM_BITS),
        .PRESCALE   (PRESCALE),
        .FADE_DIV   (FADE_DIV),
        .DECAY_STEP (DECAY_STEP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .led_in        (led_in),
        .brightness    (brightness),
        .fade_en       (fade_en),
        .led_out       (led_out),
        .period_strobe (period_strobe)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_ticks   = 0;
        m_periods = 0;
        m_led_in  = '0;
        m_out     = '0;
        m_strobe  = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) m_level[i] = 0;
    endtask

    task automatic modelEdge();
        int  phase;
        bit  wrap;
        bit  fade;
        if (reset) begin
            modelReset();
            return;
        end
        if (enable) begin
            phase = m_ticks % PERIOD;
            for (int i = 0; i < NUM_LEDS; i++)
                m_out[i] = (m_level[i] == PERIOD - 1) || (phase < m_level[i]);
            wrap     = (phase == PERIOD - 1);
            m_strobe = wrap;
            if (wrap) begin
                fade = ((m_periods % FADE_DIV) == FADE_DIV - 1);
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (m_led_in[i])  m_level[i] = int'(brightness);
                    else if (!fade_en) m_level[i] = 0;
                    else if (fade)     m_level[i] = (m_level[i] > DECAY_STEP) ? m_level[i] - DECAY_STEP : 0;
                end
                m_periods++;
            end
            m_ticks++;
        end else begin
            m_out    = '0;
            m_strobe = 1'b0;
        end
        m_led_in = led_in;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("model_led_out", 32'(led_out), 32'(m_out));
        checkOutput("model_strobe", 32'(period_strobe), 32'(m_strobe));
    endtask

    task automatic stepN(input int n);
        for (int k = 0; k < n; k++) stepCycle();
    endtask

    task automatic applyStimulus(input logic [NUM_LEDS-1:0] leds, input logic [PWM_BITS-1:0] bright,
                                 input logic fade, input logic en);
        led_in     = leds;
        brightness = bright;
        fade_en    = fade;
        enable     = en;
    endtask

    task automatic countToStrobe(output int n);
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (!period_strobe && n < WAIT_LIMIT);
    endtask

    task automatic waitStrobe();
        int n;
        countToStrobe(n);
        checkOutput("strobe_seen", 32'(n < WAIT_LIMIT), 32'd1);
    endtask

    task automatic highTime(input int idx, output int hi);
        hi = 0;
        for (int k = 0; k < PERIOD; k++) begin
            stepCycle();
            hi += int'(led_out[idx]);
        end
    endtask

    initial begin
        int hi;
        int n;

        reset = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0);
        modelReset();
        stepN(2);
        checkOutput("reset_led_out", 32'(led_out), 32'd0);
        checkOutput("reset_strobe", 32'(period_strobe), 32'd0);
        reset = 1'b0;

        $display("[TB] async reset mid-run");
        applyStimulus(10'h3FF, 8'd128, 1'b0, 1'b1);
        stepN(300);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("async_reset_led_out", 32'(led_out), 32'd0);
        checkOutput("async_reset_strobe", 32'(period_strobe), 32'd0);
        stepN(3);
        reset = 1'b0;
        stepN(200);
        checkOutput("relight_waits_period", 32'(led_out), 32'd0);

        $display("[TB] brightness 64 on led 0");
        applyStimulus(10'h001, 8'd64, 1'b0, 1'b1);
        stepN(300);
        waitStrobe();
        highTime(0, hi);
        checkOutput("duty64_led0", 32'(hi), 32'd64);
        highTime(1, hi);
        checkOutput("duty64_led1_off", 32'(hi), 32'd0);
        countToStrobe(n);
        checkOutput("strobe_interval", 32'(n), 32'(PERIOD));

        $display("[TB] full brightness then zero on led 9");
        applyStimulus(10'h200, 8'd255, 1'b0, 1'b1);
        stepN(300);
        waitStrobe();
        highTime(9, hi);
        checkOutput("full_on_led9", 32'(hi), 32'(PERIOD));
        brightness = 8'd0;
        highTime(9, hi);
        checkOutput("full_on_until_period", 32'(hi), 32'(PERIOD));
        highTime(9, hi);
        checkOutput("zero_brightness_led9", 32'(hi), 32'd0);

        $display("[TB] fade on led 2");
        applyStimulus(10'h004, 8'd200, 1'b1, 1'b1);
        stepN(300);
        waitStrobe();
        led_in = '0;
        for (int s = 0; s < 6; s++) begin
            highTime(2, hi);
            checkOutput($sformatf("fade_period%0d", s), 32'(hi), 32'((200 - 50 * s) > 0 ? (200 - 50 * s) : 0));
        end

        applyStimulus(10'h004, 8'd200, 1'b0, 1'b1);
        stepN(300);
        waitStrobe();
        led_in = '0;
        highTime(2, hi);
        checkOutput("nofade_last_period", 32'(hi), 32'd200);
        highTime(2, hi);
        checkOutput("nofade_off", 32'(hi), 32'd0);

        $display("[TB] relight wins over fade step on led 3");
        applyStimulus(10'h008, 8'd200, 1'b1, 1'b1);
        stepN(300);
        waitStrobe();
        led_in = '0;
        highTime(3, hi);
        highTime(3, hi);
        checkOutput("fade_to_150", 32'(hi), 32'd150);
        applyStimulus(10'h008, 8'd180, 1'b1, 1'b1);
        highTime(3, hi);
        checkOutput("level_100", 32'(hi), 32'd100);
        highTime(3, hi);
        checkOutput("relight_wins", 32'(hi), 32'd180);

        $display("[TB] enable freeze at count 37");
        waitStrobe();
        stepN(37);
        enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            stepCycle();
            checkOutput("disabled_led_out", 32'(led_out), 32'd0);
        end
        enable = 1'b1;
        countToStrobe(n);
        checkOutput("resume_from_37", 32'(n), 32'(PERIOD - 37));
        countToStrobe(n);
        checkOutput("period_after_resume", 32'(n), 32'(PERIOD));

        $display("[TB] random phase");
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 99) < 2) led_in = NUM_LEDS'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                case ($urandom_range(0, 3))
                    0:       brightness = 8'd0;
                    1:       brightness = 8'd255;
                    default: brightness = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 499) == 0) fade_en = ~fade_en;
            if ($urandom_range(0, 199) == 0) enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1999) == 0) begin
                #2;
                reset = 1'b1;
                modelReset();
                #1;
                checkOutput("random_async_reset", 32'(led_out), 32'd0);
                stepCycle();
                reset = 1'b0;
            end
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
